// File: rtl/aes_round_sequencer_if.sv
// Control bundle between the core wrapper and the AES round sequencer.
// The wrapper (master) issues start/destruction requests; the sequencer
// (slave) returns status, phase strobes, round index and round constant.
interface aes_round_sequencer_if;
  logic       start_i;
  logic       destruct_req_i;
  logic       busy_o;
  logic       done_o;
  logic       ctrl_start_o;
  logic       ctrl_st_ke_o;
  logic       ctrl_st_code_o;
  logic       ctrl_last_o;
  logic       ctrl_st_out_o;
  logic       ctrl_st_unmask_o;
  logic       key_destruct_o;
  logic [3:0] round_o;
  logic [7:0] rcon_o;

  modport master (
    output start_i, destruct_req_i,
    input  busy_o, done_o, ctrl_start_o, ctrl_st_ke_o, ctrl_st_code_o,
           ctrl_last_o, ctrl_st_out_o, ctrl_st_unmask_o, key_destruct_o,
           round_o, rcon_o
  );

  modport slave (
    input  start_i, destruct_req_i,
    output busy_o, done_o, ctrl_start_o, ctrl_st_ke_o, ctrl_st_code_o,
           ctrl_last_o, ctrl_st_out_o, ctrl_st_unmask_o, key_destruct_o,
           round_o, rcon_o
  );
endinterface

// File: rtl/aes_round_sequencer.sv
// Control FSM for the masked AES-128 datapath: load, NROUNDS combined
// code/key-expansion rounds, output, optional unmask, then done. Key
// destruction requests are run from IDLE, deferred while an operation is busy.
module aes_round_sequencer #(
  parameter int unsigned NROUNDS         = 10,
  parameter int unsigned SHARES_EN       = 1,
  parameter int unsigned DESTRUCT_CYCLES = 2
) (
  input logic                 clk_i,
  input logic                 srst_i,
  aes_round_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ROUND,
    S_OUT,
    S_UNMASK,
    S_DESTRUCT
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'(NROUNDS);
  localparam logic [3:0] LAST_DCNT  = 4'(DESTRUCT_CYCLES - 1);
  localparam bit         SHARES     = (SHARES_EN != 0);

  state_t     state_q, state_d;
  logic [3:0] round_q, round_d;
  logic [7:0] rcon_q,  rcon_d;
  logic [3:0] dcnt_q,  dcnt_d;
  logic       pend_q,  pend_d;
  logic       done_q,  done_d;

  // GF(2^8) doubling modulo the AES polynomial, producing the next Rcon.
  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1B : 8'h00);
  endfunction

  // State, round/rcon, destruct bookkeeping and done pulse registers.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= S_IDLE;
      round_q <= '0;
      rcon_q  <= '0;
      dcnt_q  <= '0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
      dcnt_q  <= dcnt_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic. round/rcon fall back to zero so they read 0 outside ROUND.
  always_comb begin
    state_d = state_q;
    round_d = '0;
    rcon_d  = '0;
    dcnt_d  = '0;
    pend_d  = pend_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Destruction wins over a simultaneous start; that start is dropped.
        if (bus.destruct_req_i || pend_q) state_d = S_DESTRUCT;
        else if (bus.start_i)             state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d = S_ROUND;
        round_d = 4'd1;
        rcon_d  = 8'h01;
      end
      S_ROUND: begin
        if (round_q == LAST_ROUND) begin
          state_d = S_OUT;
        end else begin
          round_d = round_q + 4'd1;
          rcon_d  = xtime(rcon_q);
        end
      end
      S_OUT: begin
        if (SHARES) begin
          state_d = S_UNMASK;
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_UNMASK: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      S_DESTRUCT: begin
        if (dcnt_q == LAST_DCNT) state_d = S_IDLE;
        else                     dcnt_d  = dcnt_q + 4'd1;
      end
      default: state_d = S_IDLE;
    endcase

    // Pending flag: cleared on entry to DESTRUCT, set by any request while busy.
    if (state_q == S_IDLE && state_d == S_DESTRUCT) pend_d = 1'b0;
    else if (state_q != S_IDLE && bus.destruct_req_i) pend_d = 1'b1;
  end

  // Moore output decode from the registered state only.
  assign bus.busy_o           = (state_q != S_IDLE);
  assign bus.done_o           = done_q;
  assign bus.ctrl_start_o     = (state_q == S_LOAD);
  assign bus.ctrl_st_ke_o     = (state_q == S_ROUND);
  assign bus.ctrl_st_code_o   = (state_q == S_ROUND);
  assign bus.ctrl_last_o      = (state_q == S_ROUND) && (round_q == LAST_ROUND);
  assign bus.ctrl_st_out_o    = (state_q == S_OUT);
  assign bus.ctrl_st_unmask_o = (state_q == S_UNMASK) || (!SHARES && state_q == S_OUT);
  assign bus.key_destruct_o   = (state_q == S_DESTRUCT);
  assign bus.round_o          = round_q;
  assign bus.rcon_o           = rcon_q;

endmodule
